seq_detect_ctrl: RTL and testbench
==================================

Name: seq_detect_ctrl

Overview:
- Run controller for our serial sequence-detector datapath.
- Accepts parallel bytes over a valid/ready handshake and serialises them MSB-first, one bit per clock.
- Feeds each bit into a programmable pattern matcher (1..8 bits, overlapping or non-overlapping mode), counts matches and stops the run at a programmed match target.
- Sits between the byte source (UART/FIFO side) and the status/interrupt logic.

Parameters:
- PAT_W, 8, maximum pattern length in bits; also the input word width.
- CNT_W, 8, width of the match counter and the target.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  pulse; latches the config and begins a run (honoured in IDLE and DONE)
- stop  in  1  pulse; aborts the run to DONE
- pattern  in  PAT_W  pattern bits; bit 0 = most recent bit
- pat_len  in  4  pattern length; 0 is clamped to 1, values >PAT_W are clamped to PAT_W
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping
- target  in  CNT_W  match count that ends the run; 0 = run until stop
- in_valid  in  1  input byte valid
- in_data  in  PAT_W  input byte, transmitted MSB first
- in_ready  out  1  controller can accept a byte this cycle
- match  out  1  one-cycle pulse, registered, one cycle after the matching bit is consumed
- match_count  out  CNT_W  matches in the current run, saturating
- busy  out  1  high in RUN
- done  out  1  high in DONE

Behaviour:
- **Reset:** the synchronous reset has priority over everything. It sets state to IDLE and clears in_ready, match, match_count, busy, done, the history, the fill counter and the bit counter. A reset asserted mid-run discards any partial byte.
- **States:**
  - IDLE → RUN on start.
  - RUN → DONE when stop is asserted, or when target≠0 and the updated count equals target.
  - DONE → RUN on start.
  - done stays high in DONE until start.
- **Start:**
  - Latches pattern, the clamped pat_len, overlap and target.
  - Clears match_count, history, fill and the held byte.
  - Config inputs are ignored while in RUN.
- **Handshake:**
  - in_ready = RUN and (no byte held, or the held byte is on bit index 7).
  - A byte transfers when in_valid && in_ready.
  - Transfer on bit 7 gives back-to-back bytes with no bubble.
  - in_ready is 0 in IDLE and DONE.
- **Serialisation:**
  - While a byte is held, one bit is consumed per cycle, index 0..7, bit = data[7-idx].
  - No bits are consumed when no byte is held.
- **Matcher, per consumed bit b:**
  - win = {hist[PAT_W-2:0], b}; hist <= win.
  - fill <= min(fill+1, PAT_W).
  - hit = (fill+1 >= len) and (win & mask(len)) == (pattern & mask(len)).
- **On hit:**
  - match is pulsed on the next cycle.
  - match_count increments, saturating at 2^CNT_W-1.
  - If overlap=0, fill <= 0 (history bits are retained but are masked by fill).
- **Target reached:**
  - The transition to DONE happens in the same cycle as the hit.
  - The rest of the held byte is discarded.
  - The match pulse for that hit still fires.
- **Stop:** stop in RUN goes to DONE next cycle; the bit consumed in that cycle is still evaluated.
- **Simultaneous events:**
  - stop together with a target hit → DONE, and the count includes the hit.
  - start together with stop in DONE → start wins.
- **Stall:** an in_valid gap leaves hist and fill unchanged; the pattern spans byte boundaries.

Decomposition:
- **Shared package seq_detect_pkg:**
  - state enum {IDLE, RUN, DONE}
  - PAT_W and CNT_W defaults
  - a len-clamp function
  - a mask(len) function
- **Natural sub-module seq_pattern_match:**
  - history, fill and hit logic.
  - Inputs: bit_valid, bit, pattern, len, overlap.
  - Outputs: hit.
  - Clear input driven on start.
- The controller owns the FSM, handshake, serialiser and counter.

Test Plan:
- **Non-overlap:** pattern=4'b1011, len=4, overlap=0, target=0, byte 0xB6 → one match pulse, 5 cycles after the transfer (bit idx 3); match_count=1.
- **Overlap:** same as above with overlap=1 → match pulses after bit idx 3 and idx 6; match_count=2.
- **Target stop:**
  - Setup: pattern=1, len=1, target=3, byte 0xFF.
  - Required: three consecutive match pulses; done rises with busy falling one cycle after the 3rd bit; in_ready=0; bits 3..7 discarded; count=3.
- **Back-to-back and boundary:**
  - Setup: bytes 0x01 then 0x80, in_valid held high; pattern 2'b11, overlap=0.
  - Required: in_ready high at bit idx 7 and no idle cycle; one match across the byte boundary; count=1.
- **Clamp and stall:**
  - Setup: pat_len=0 (acts as 1), pattern bit0=0, byte 0x0F with a 3-cycle in_valid gap before the next byte.
  - Required: count=4; no bits consumed during the gap.
- **Reset mid-run:** reset asserted at bit idx 4 → next cycle all outputs 0, state IDLE; a later start with a fresh byte behaves as from power-up.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the serial sequence-detector run controller.
// Holds the FSM state type, default widths, and pattern-length helpers.
package seq_detect_pkg;

    localparam int PAT_W_DEF = 8;
    localparam int CNT_W_DEF = 8;
    localparam int MASK_W    = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // A length of 0 behaves as 1; anything wider than the window is cut to the window.
    function automatic logic [3:0] clamp_len(input logic [3:0] len, input int unsigned max_w);
        if (len == 4'd0) return 4'd1;
        if (32'(len) > max_w) return 4'(max_w);
        return len;
    endfunction

    function automatic logic [MASK_W-1:0] len_mask(input logic [3:0] len);
        return (MASK_W'(1) << len) - MASK_W'(1);
    endfunction

endpackage

// File: rtl/seq_pattern_match.sv
// Bit-serial pattern matcher: shift history, fill tracking and hit detection.
// hit_o is combinational for the bit presented on bit_i this cycle.
module seq_pattern_match
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             bit_valid_i,
    input  logic             bit_i,
    input  logic [PAT_W-1:0] pattern_i,
    input  logic [3:0]       len_i,
    input  logic             overlap_i,
    output logic             hit_o
);

    localparam int FILL_W = $clog2(PAT_W + 1);

    logic [PAT_W-2:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0]  win;
    logic [MASK_W-1:0] mask;
    logic              len_ok;
    logic              hit;

    always_comb begin
        win    = {hist_q, bit_i};
        mask   = len_mask(len_i);
        len_ok = (32'(fill_q) + 32'd1) >= 32'(len_i);
        hit    = bit_valid_i && len_ok &&
                 ((MASK_W'(win) & mask) == (MASK_W'(pattern_i) & mask));

        hist_d = hist_q;
        fill_d = fill_q;
        if (clear_i) begin
            hist_d = '0;
            fill_d = '0;
        end else if (bit_valid_i) begin
            hist_d = win[PAT_W-2:0];
            // Non-overlapping mode forgets the history by zeroing fill, not the bits.
            if (hit && !overlap_i) begin
                fill_d = '0;
            end else if (32'(fill_q) < PAT_W) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    assign hit_o = hit;

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller: byte handshake, MSB-first serialiser, match counter and run FSM
// wrapped around the bit-serial pattern matcher.
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [PAT_W-1:0] pattern,
    input  logic [3:0]       pat_len,
    input  logic             overlap,
    input  logic [CNT_W-1:0] target,
    input  logic             in_valid,
    input  logic [PAT_W-1:0] in_data,
    output logic             in_ready,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = $clog2(PAT_W);

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [PAT_W-1:0] data_q, data_d;
    logic [3:0]       len_q, len_d;
    logic             ovl_q, ovl_d;
    logic [CNT_W-1:0] tgt_q, tgt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             held_q, held_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             match_q, match_d;

    logic             bit_valid;
    logic             clear;
    logic             take;
    logic             hit;
    logic             tgt_hit;
    logic [CNT_W-1:0] cnt_inc;

    assign in_ready  = (state_q == RUN) && (!held_q || idx_q == IDX_W'(PAT_W - 1));
    assign bit_valid = (state_q == RUN) && held_q;
    assign clear     = start && (state_q != RUN);
    assign take      = in_valid && in_ready;
    assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    assign tgt_hit   = hit && (tgt_q != '0) && (cnt_inc == tgt_q);

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        held_d  = held_q;
        idx_d   = idx_q;
        match_d = hit;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    pat_d   = pattern;
                    len_d   = clamp_len(pat_len, PAT_W);
                    ovl_d   = overlap;
                    tgt_d   = target;
                    cnt_d   = '0;
                    held_d  = 1'b0;
                    idx_d   = '0;
                end
            end
            RUN: begin
                if (hit) cnt_d = cnt_inc;
                if (bit_valid) begin
                    data_d = data_q << 1;
                    idx_d  = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(PAT_W - 1)) held_d = 1'b0;
                end
                // Ending the run drops whatever is left of the held byte.
                if (stop || tgt_hit) begin
                    state_d = DONE;
                    held_d  = 1'b0;
                end else if (take) begin
                    data_d = in_data;
                    held_d = 1'b1;
                    idx_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            held_q  <= 1'b0;
            idx_q   <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            held_q  <= held_d;
            idx_q   <= idx_d;
            match_q <= match_d;
        end
    end

    always_ff @(posedge clk) begin
        pat_q  <= pat_d;
        len_q  <= len_d;
        ovl_q  <= ovl_d;
        tgt_q  <= tgt_d;
        data_q <= data_d;
    end

    seq_pattern_match #(
        .PAT_W(PAT_W)
    ) u_match (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (clear),
        .bit_valid_i(bit_valid),
        .bit_i      (data_q[PAT_W-1]),
        .pattern_i  (pat_q),
        .len_i      (len_q),
        .overlap_i  (ovl_q),
        .hit_o      (hit)
    );

    assign match       = match_q;
    assign match_count = cnt_q;
    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: directed run scenarios followed by random traffic,
// all compared every cycle against a bit-stream reference model.
module tb_seq_detect_ctrl;

    logic       clk = 1'b0;
    logic       reset, start, stop, overlap, in_valid;
    logic [7:0] pattern, in_data, target;
    logic [3:0] pat_len;
    logic       in_ready, match, busy, done;
    logic [7:0] match_count;

    seq_detect_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .pattern    (pattern),
        .pat_len    (pat_len),
        .overlap    (overlap),
        .target     (target),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .match      (match),
        .match_count(match_count),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int tot_cnt  = 0;
    int pass_cnt = 0;

    // Reference model: run phase, the bits still waiting in the held byte, and
    // the full stream of bits consumed since start.
    int         m_phase;      // 0 idle, 1 running, 2 finished
    bit         m_bits[$];
    bit         m_stream[$];
    int         m_since;      // bits usable by the next match
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ovl;
    int         m_tgt;
    int         m_cnt;
    bit         m_match;
    bit         m_took;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tot_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic bit m_ready();
        return (m_phase == 1) && (m_bits.size() <= 1);
    endfunction

    task automatic model_step();
        bit hit;
        bit rdy;
        bit b;
        bit ok;
        if (reset) begin
            m_phase = 0;
            m_bits.delete();
            m_stream.delete();
            m_since = 0;
            m_cnt   = 0;
            m_match = 0;
            return;
        end
        hit = 0;
        if (m_phase != 1) begin
            m_match = 0;
            if (start) begin
                m_pat = pattern;
                m_len = (pat_len == 0) ? 1 : ((pat_len > 8) ? 8 : int'(pat_len));
                m_ovl = overlap;
                m_tgt = int'(target);
                m_cnt = 0;
                m_stream.delete();
                m_bits.delete();
                m_since = 0;
                m_phase = 1;
            end
        end else begin
            rdy = m_ready();
            if (m_bits.size() > 0) begin
                b = m_bits.pop_front();
                m_stream.push_back(b);
                m_since++;
                if (m_since >= m_len) begin
                    ok = 1;
                    for (int k = 0; k < m_len; k++)
                        if (m_stream[m_stream.size() - 1 - k] != m_pat[k]) ok = 0;
                    hit = ok;
                end
                if (hit) begin
                    if (m_cnt < 255) m_cnt++;
                    if (!m_ovl) m_since = 0;
                end
            end
            m_match = hit;
            if (stop || (hit && m_tgt != 0 && m_cnt == m_tgt)) begin
                m_phase = 2;
                m_bits.delete();
            end else if (in_valid && rdy) begin
                for (int i = 7; i >= 0; i--) m_bits.push_back(in_data[i]);
                m_took = 1;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready()});
        model_step();
        @(posedge clk);
        #1;
        chk("match", {31'd0, match}, {31'd0, m_match});
        chk("match_count", {24'd0, match_count}, 32'(m_cnt));
        chk("busy", {31'd0, busy}, {31'd0, m_phase == 1});
        chk("done", {31'd0, done}, {31'd0, m_phase == 2});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_byte(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        m_took   = 0;
        for (int i = 0; i < 40 && !m_took; i++) tick();
        if (!m_took) begin
            tot_cnt++;
            $error("FAIL accept_timeout observed=no_transfer expected=transfer data=%0h", d);
        end
    endtask

    task automatic do_start(input logic [7:0] p, input logic [3:0] l, input logic o, input logic [7:0] t);
        pattern = p;
        pat_len = l;
        overlap = o;
        target  = t;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; overlap = 1'b0; in_valid = 1'b0;
        pattern = '0; in_data = '0; target = '0; pat_len = '0;
        m_took = 0;
        repeat (2) @(posedge clk);
        #1;
        model_step();
        tick();
        reset = 1'b0;
        chk("rst_count", {24'd0, match_count}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // Non-overlapping 1011 in 0xB6
        do_start(8'h0B, 4'd4, 1'b0, 8'd0);
        send_byte(8'hB6);
        in_valid = 1'b0;
        ticks(10);
        chk("nonovl_count", {24'd0, match_count}, 32'd1);
        do_stop();
        chk("stop_done", {31'd0, done}, 32'd1);

        // Overlapping 1011 in 0xB6
        do_start(8'h0B, 4'd4, 1'b1, 8'd0);
        send_byte(8'hB6);
        in_valid = 1'b0;
        ticks(10);
        chk("ovl_count", {24'd0, match_count}, 32'd2);
        do_stop();

        // Target of 3 on an all-ones byte
        do_start(8'h01, 4'd1, 1'b0, 8'd3);
        send_byte(8'hFF);
        in_valid = 1'b0;
        ticks(10);
        chk("tgt_count", {24'd0, match_count}, 32'd3);
        chk("tgt_done", {31'd0, done}, 32'd1);
        chk("tgt_ready", {31'd0, in_ready}, 32'd0);

        // Back-to-back bytes, match across the byte boundary
        do_start(8'h03, 4'd2, 1'b0, 8'd0);
        send_byte(8'h01);
        send_byte(8'h80);
        in_valid = 1'b0;
        ticks(10);
        chk("b2b_count", {24'd0, match_count}, 32'd1);
        do_stop();

        // Length clamp from 0 with a stall between bytes
        do_start(8'hFE, 4'd0, 1'b0, 8'd0);
        send_byte(8'h0F);
        in_valid = 1'b0;
        ticks(11);
        send_byte(8'hFF);
        in_valid = 1'b0;
        ticks(10);
        chk("clamp_count", {24'd0, match_count}, 32'd4);

        // start together with stop while finished
        do_stop();
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("start_wins", {31'd0, busy}, 32'd1);

        // Reset in the middle of a byte
        do_stop();
        do_start(8'h0B, 4'd4, 1'b0, 8'd0);
        send_byte(8'hB6);
        in_valid = 1'b0;
        ticks(4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_count", {24'd0, match_count}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
        tick();
        do_start(8'h0B, 4'd4, 1'b0, 8'd0);
        send_byte(8'hB6);
        in_valid = 1'b0;
        ticks(10);
        chk("post_rst_count", {24'd0, match_count}, 32'd1);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            reset    = ($urandom_range(0, 249) == 0);
            start    = ($urandom_range(0, 19) == 0);
            stop     = ($urandom_range(0, 49) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = 8'($urandom);
            pattern  = 8'($urandom);
            pat_len  = 4'($urandom_range(0, 15));
            overlap  = 1'($urandom);
            target   = 8'($urandom_range(0, 6));
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
